uart_fifo: RTL and testbench

//   Buffered, programmable-baud UART peripheral on the CPU register bus: successor to the

---
 rtl/uart_fifo.sv | 327 ++++++++++++++++++++++++++++++++
 tb/tb_uart_fifo.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo.sv
// uart_fifo: register-bus UART with TX FIFO, programmable baud divisor, sticky error
// flags and (with UART_RX_EN defined) an RX path with RX FIFO. 8N1 framing.
// Latency: reads are combinational; TX low one cycle after a byte is popped from the FIFO.
// Backpressure: none on the bus; writes to a full FIFO are dropped and flagged (TX_OVF/RX_OVF).
//
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   ADDRESS         register select (0x00 TX data, 0x01 status, 0x02 RX data, 0x03 DIV)
//   DATA_IN/OUT     bus write / combinational read data
//   WRb, RDb        active-low write / read strobes (RDb pops RX FIFO at 0x02)
//   RX, TX          serial in (synchronised) / serial out, both idle high
// Optional feature macro: UART_RX_EN (RX FSM + RX FIFO); without it RX is ignored.

module uart_fifo #(
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD_RATE  = 115200,
  parameter int BITS       = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [7:0]      ADDRESS,
  input  logic [BITS-1:0] DATA_IN,
  output logic [BITS-1:0] DATA_OUT,
  input  logic            WRb,
  input  logic            RDb,
  input  logic            RX,
  output logic            TX
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]  FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0]  DIV_RST  = 16'(CLK_FREQ / BAUD_RATE - 1);

  // ---------------- bus decode ----------------
  logic        wr_tx_dat, wr_stat, wr_div;
  logic [15:0] wr_val;
  assign wr_tx_dat = !WRb && (ADDRESS == 8'h00);
  assign wr_stat   = !WRb && (ADDRESS == 8'h01);
  assign wr_div    = !WRb && (ADDRESS == 8'h03);
  assign wr_val    = 16'(DATA_IN);

  // ---------------- baud divisor ----------------
  logic [15:0] div_q, div_d;
  // Next-cycle divisor: reloads pick up a write made in the same cycle.
  assign div_d = wr_div ? wr_val : div_q;

  always_ff @(posedge CLK) begin
    if (RST) div_q <= DIV_RST;
    else     div_q <= div_d;
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp_q, tx_rp_q;
  logic [AW:0]   tx_cnt_q, tx_cnt_d;
  logic          tx_empty, tx_full, tx_push, tx_pop, tx_drop;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  tx_state_e   tx_st_q;
  logic [15:0] tx_bcnt_q;
  logic [7:0]  tx_sh_q;
  logic [2:0]  tx_bit_q;
  logic        tx_q;
  logic        tx_tick;

  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == FULL_CNT);
  assign tx_tick  = (tx_bcnt_q == 16'd0);
  // Pop when idle, or at the end of a stop bit so frames run back-to-back.
  assign tx_pop   = !tx_empty && ((tx_st_q == TX_IDLE) || ((tx_st_q == TX_STOP) && tx_tick));
  // A pop in the same cycle frees a slot, so a push into a full FIFO still succeeds.
  assign tx_push  = wr_tx_dat && (!tx_full || tx_pop);
  assign tx_drop  = wr_tx_dat && tx_full && !tx_pop;

  always_comb begin
    tx_cnt_d = tx_cnt_q;
    case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
      2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
      default: tx_cnt_d = tx_cnt_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (tx_push) tx_mem[tx_wp_q] <= DATA_IN[7:0];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
      if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
      tx_cnt_q <= tx_cnt_d;
    end
  end

  // ---------------- TX FSM ----------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_st_q   <= TX_IDLE;
      tx_bcnt_q <= DIV_RST;
      tx_sh_q   <= '0;
      tx_bit_q  <= '0;
      tx_q      <= 1'b1;
    end else begin
      case (tx_st_q)
        TX_IDLE: begin
          tx_bcnt_q <= div_d;
          if (!tx_empty) begin
            tx_sh_q <= tx_mem[tx_rp_q];
            tx_q    <= 1'b0;
            tx_st_q <= TX_START;
          end
        end
        TX_START: begin
          if (tx_tick) begin
            tx_bcnt_q <= div_d;
            tx_q      <= tx_sh_q[0];
            tx_sh_q   <= tx_sh_q >> 1;
            tx_bit_q  <= '0;
            tx_st_q   <= TX_DATA;
          end else begin
            tx_bcnt_q <= tx_bcnt_q - 16'd1;
          end
        end
        TX_DATA: begin
          if (tx_tick) begin
            tx_bcnt_q <= div_d;
            if (tx_bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              tx_st_q <= TX_STOP;
            end else begin
              tx_q     <= tx_sh_q[0];
              tx_sh_q  <= tx_sh_q >> 1;
              tx_bit_q <= tx_bit_q + 3'd1;
            end
          end else begin
            tx_bcnt_q <= tx_bcnt_q - 16'd1;
          end
        end
        default: begin // TX_STOP
          if (tx_tick) begin
            tx_bcnt_q <= div_d;
            if (!tx_empty) begin
              tx_sh_q <= tx_mem[tx_rp_q];
              tx_q    <= 1'b0;
              tx_st_q <= TX_START;
            end else begin
              tx_st_q <= TX_IDLE;
            end
          end else begin
            tx_bcnt_q <= tx_bcnt_q - 16'd1;
          end
        end
      endcase
    end
  end

  assign TX = tx_q;

  logic tx_ovf_q;
  always_ff @(posedge CLK) begin
    if (RST)                         tx_ovf_q <= 1'b0;
    else if (tx_drop)                tx_ovf_q <= 1'b1;
    else if (wr_stat && wr_val[4])   tx_ovf_q <= 1'b0;
  end

  // ---------------- RX path ----------------
  logic       rx_avail, rx_ovf, rx_ferr;
  logic [7:0] rx_head;

`ifdef UART_RX_EN
  logic rx_s1_q, rx_s2_q, rx_s3_q;
  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
    end else begin
      rx_s1_q <= RX;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
    end
  end

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  rx_state_e   rx_st_q;
  logic [15:0] rx_bcnt_q, rx_half;
  logic [16:0] rx_div_p1;
  logic [7:0]  rx_sh_q;
  logic [2:0]  rx_bit_q;
  logic        rx_tick, rx_stop_ok, rx_stop_bad;

  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wp_q, rx_rp_q;
  logic [AW:0]   rx_cnt_q, rx_cnt_d;
  logic          rx_empty, rx_full, rx_push, rx_pop, rx_drop;
  logic          rx_ovf_q, rx_ferr_q;

  // First sample lands mid start bit: (DIV+1)/2 clocks after the edge.
  assign rx_div_p1   = {1'b0, div_q} + 17'd1;
  assign rx_half     = rx_div_p1[16:1] - 16'd1;
  assign rx_tick     = (rx_bcnt_q == 16'd0);
  assign rx_stop_ok  = (rx_st_q == RX_STOP) && rx_tick && rx_s2_q;
  assign rx_stop_bad = (rx_st_q == RX_STOP) && rx_tick && !rx_s2_q;

  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == FULL_CNT);
  assign rx_pop   = !RDb && (ADDRESS == 8'h02) && !rx_empty;
  assign rx_push  = rx_stop_ok && (!rx_full || rx_pop);
  assign rx_drop  = rx_stop_ok && rx_full && !rx_pop;

  always_comb begin
    rx_cnt_d = rx_cnt_q;
    case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
      2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
      default: rx_cnt_d = rx_cnt_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rx_push) rx_mem[rx_wp_q] <= rx_sh_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
      if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
      rx_cnt_q <= rx_cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_st_q   <= RX_IDLE;
      rx_bcnt_q <= '0;
      rx_sh_q   <= '0;
      rx_bit_q  <= '0;
    end else begin
      case (rx_st_q)
        RX_IDLE: begin
          if (rx_s3_q && !rx_s2_q) begin
            rx_bcnt_q <= rx_half;
            rx_st_q   <= RX_START;
          end
        end
        RX_START: begin
          if (rx_tick) begin
            if (!rx_s2_q) begin
              rx_bcnt_q <= div_q;
              rx_bit_q  <= '0;
              rx_st_q   <= RX_DATA;
            end else begin
              rx_st_q <= RX_IDLE; // glitch, not a real start bit
            end
          end else begin
            rx_bcnt_q <= rx_bcnt_q - 16'd1;
          end
        end
        RX_DATA: begin
          if (rx_tick) begin
            rx_bcnt_q <= div_q;
            rx_sh_q   <= {rx_s2_q, rx_sh_q[7:1]};
            if (rx_bit_q == 3'd7) rx_st_q <= RX_STOP;
            else                  rx_bit_q <= rx_bit_q + 3'd1;
          end else begin
            rx_bcnt_q <= rx_bcnt_q - 16'd1;
          end
        end
        default: begin // RX_STOP: push/flag decided combinationally at the tick
          if (rx_tick) rx_st_q <= RX_IDLE;
          else         rx_bcnt_q <= rx_bcnt_q - 16'd1;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_ovf_q  <= 1'b0;
      rx_ferr_q <= 1'b0;
    end else begin
      if (rx_drop)                     rx_ovf_q <= 1'b1;
      else if (wr_stat && wr_val[3])   rx_ovf_q <= 1'b0;
      if (rx_stop_bad)                 rx_ferr_q <= 1'b1;
      else if (wr_stat && wr_val[5])   rx_ferr_q <= 1'b0;
    end
  end

  assign rx_avail = !rx_empty;
  assign rx_ovf   = rx_ovf_q;
  assign rx_ferr  = rx_ferr_q;
  assign rx_head  = rx_empty ? 8'h00 : rx_mem[rx_rp_q];
`else
  logic unused_rx_inputs;
  assign unused_rx_inputs = ^{RX, RDb};
  assign rx_avail = 1'b0;
  assign rx_ovf   = 1'b0;
  assign rx_ferr  = 1'b0;
  assign rx_head  = 8'h00;
`endif

  // ---------------- read mux ----------------
  logic [5:0] status;
  assign status = {rx_ferr, tx_ovf_q, rx_ovf, rx_avail, tx_full,
                   (tx_empty && (tx_st_q == TX_IDLE))};

  always_comb begin
    DATA_OUT = '0;
    case (ADDRESS)
      8'h01:   DATA_OUT = BITS'(status);
      8'h02:   DATA_OUT = BITS'(rx_head);
      8'h03:   DATA_OUT = BITS'(div_q);
      default: DATA_OUT = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_fifo.sv
// tb_uart_fifo: directed bench for uart_fifo (TX framing, FIFO overflow, divisor change,
// RX path or its absence, reset mid-frame).
// Inputs change on the falling edge; outputs are observed on the falling edge.

module tb_uart_fifo;
  localparam int DEPTH = 16;

  logic        CLK = 1'b0;
  logic        RST, WRb, RDb, RX;
  logic [7:0]  ADDRESS;
  logic [15:0] DATA_IN, DATA_OUT;
  logic        TX;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] d;
  logic [9:0]  fr;
  logic [7:0]  eb;
  int          n;
  bit          ok;

  always #5 CLK = ~CLK;

  uart_fifo #(.CLK_FREQ(12000000), .BAUD_RATE(115200), .BITS(16), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .ADDRESS(ADDRESS), .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT),
    .WRb(WRb), .RDb(RDb), .RX(RX), .TX(TX)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] v);
    ADDRESS = a; DATA_IN = v; WRb = 1'b0;
    @(negedge CLK);
    WRb = 1'b1;
  endtask

  task automatic rd(input logic [7:0] a, output logic [15:0] v);
    ADDRESS = a;
    #1 v = DATA_OUT;
  endtask

  task automatic pop_rx();
    ADDRESS = 8'h02; RDb = 1'b0;
    @(negedge CLK);
    RDb = 1'b1;
  endtask

  task automatic cycles(input int k);
    repeat (k) @(negedge CLK);
  endtask

  task automatic wait_tx_fall(output bit found);
    found = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (TX === 1'b0) begin found = 1'b1; break; end
      @(negedge CLK);
    end
  endtask

  task automatic run_len(input logic lvl, output int len);
    len = 0;
    while (TX === lvl && len < 5000) begin
      @(negedge CLK);
      len++;
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop, input int per);
    RX = 1'b0; cycles(per);
    for (int i = 0; i < 8; i++) begin RX = b[i]; cycles(per); end
    RX = stop; cycles(per);
    RX = 1'b1; cycles(per);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST = 1'b1; WRb = 1'b1; RDb = 1'b1; RX = 1'b1; ADDRESS = 8'h00; DATA_IN = 16'h0000;
    cycles(3);
    RST = 1'b0;
    cycles(1);

    // ---- reset state ----
    check("rst_tx", 32'(TX), 32'd1);
    rd(8'h01, d); check("rst_status", 32'(d), 32'h0001);
    rd(8'h03, d); check("rst_div", 32'(d), 32'd103);
    rd(8'h02, d); check("rst_rxdata", 32'(d), 32'h0000);
    rd(8'h10, d); check("unmapped", 32'(d), 32'h0000);

    // ---- 1: 0x55 at DIV=103 ----
    wr(8'h00, 16'h0055);
    wait_tx_fall(ok); check("t1_fall", 32'(ok), 32'd1);
    rd(8'h01, d); check("t1_busy", 32'(d[0]), 32'd0);
    run_len(1'b0, n); check("t1_start", 32'(n), 32'd104);
    for (int i = 0; i < 8; i++) begin
      run_len((i % 2 == 0) ? 1'b1 : 1'b0, n);
      check($sformatf("t1_bit%0d", i), 32'(n), 32'd104);
    end
    ADDRESS = 8'h01;
    n = 0;
    while (DATA_OUT[0] === 1'b0 && n < 5000) begin @(negedge CLK); n++; end
    check("t1_stop_to_idle", 32'(n), 32'd104);
    check("t1_tx_idle", 32'(TX), 32'd1);

    // ---- 2: overflow, back-to-back frames at DIV=15 ----
    wr(8'h03, 16'd15);
    fork
      begin
        for (int i = 0; i < DEPTH + 2; i++) begin
          ADDRESS = 8'h00; DATA_IN = 16'(8'h10 + i); WRb = 1'b0;
          @(negedge CLK);
        end
        WRb = 1'b1;
        rd(8'h01, d); check("t2_full", 32'(d), 32'h0012);
      end
      begin
        wait_tx_fall(ok); check("t2_fall", 32'(ok), 32'd1);
        cycles(8);
        for (int f = 0; f < DEPTH + 1; f++) begin
          for (int j = 0; j < 10; j++) begin
            fr[j] = TX;
            cycles(16);
          end
          eb = 8'(8'h10 + f);
          check($sformatf("t2_frame%0d", f), 32'(fr), 32'({1'b1, eb, 1'b0}));
        end
      end
    join
    cycles(20);
    check("t2_tx_after", 32'(TX), 32'd1);
    rd(8'h01, d); check("t2_ovf", 32'(d), 32'h0011);
    wr(8'h01, 16'h0010);
    rd(8'h01, d); check("t2_ovf_clr", 32'(d), 32'h0001);

    // ---- 3: divisor change mid-frame ----
    wr(8'h03, 16'd31);
    wr(8'h00, 16'h0070);
    wait_tx_fall(ok); check("t3_fall", 32'(ok), 32'd1);
    n = 0;
    while (TX === 1'b0 && n < 1000) begin
      if (n == 10) begin ADDRESS = 8'h03; DATA_IN = 16'h000F; WRb = 1'b0; end
      else WRb = 1'b1;
      @(negedge CLK);
      n++;
    end
    WRb = 1'b1;
    check("t3_low1", 32'(n), 32'd96);
    run_len(1'b1, n); check("t3_high", 32'(n), 32'd48);
    run_len(1'b0, n); check("t3_low2", 32'(n), 32'd16);
    rd(8'h03, d); check("t3_div", 32'(d), 32'd15);
    cycles(30);

`ifdef UART_RX_EN
    // ---- 4: RX single frame, framing error ----
    send_rx(8'hA3, 1'b1, 16);
    rd(8'h01, d); check("t4_avail", 32'(d), 32'h0005);
    rd(8'h02, d); check("t4_data", 32'(d), 32'h00A3);
    pop_rx();
    rd(8'h01, d); check("t4_empty", 32'(d), 32'h0001);
    send_rx(8'h5A, 1'b0, 16);
    rd(8'h01, d); check("t4_ferr", 32'(d), 32'h0021);
    rd(8'h02, d); check("t4_nodata", 32'(d), 32'h0000);
    wr(8'h01, 16'h0020);
    rd(8'h01, d); check("t4_ferr_clr", 32'(d), 32'h0001);

    // ---- 5: RX overflow ----
    for (int i = 0; i < DEPTH + 1; i++) send_rx(8'(8'h30 + i), 1'b1, 16);
    rd(8'h01, d); check("t5_ovf", 32'(d), 32'h000D);
    for (int i = 0; i < DEPTH; i++) begin
      rd(8'h02, d); check($sformatf("t5_rd%0d", i), 32'(d), 32'(8'h30 + i));
      pop_rx();
    end
    rd(8'h01, d); check("t5_drained", 32'(d), 32'h0009);
    wr(8'h01, 16'h0008);
`else
    // ---- 5: RX path absent ----
    send_rx(8'hA3, 1'b1, 16);
    send_rx(8'h5A, 1'b0, 16);
    rd(8'h01, d); check("t5_norx_status", 32'(d), 32'h0001);
    rd(8'h02, d); check("t5_norx_data", 32'(d), 32'h0000);
    pop_rx();
    rd(8'h02, d); check("t5_norx_pop", 32'(d), 32'h0000);
`endif

    // ---- 6: reset mid data bit ----
    wr(8'h00, 16'h0000);
    wait_tx_fall(ok); check("t6_fall", 32'(ok), 32'd1);
    cycles(21);
    check("t6_pre", 32'(TX), 32'd0);
    RST = 1'b1;
    @(negedge CLK);
    check("t6_tx", 32'(TX), 32'd1);
    RST = 1'b0;
    rd(8'h01, d); check("t6_status", 32'(d), 32'h0001);
    rd(8'h03, d); check("t6_div", 32'(d), 32'd103);
    cycles(50);
    check("t6_tx_stays", 32'(TX), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
